simmem_release_scheduler: RTL and testbench

SIMMEM_RELEASE_SCHEDULER -- requirements
Module: simmem_release_scheduler

---
 rtl/simmem_pkg.sv | 8 +
 rtl/simmem_release_scheduler.sv | 94 +++++++++
 tb/tb_simmem_release_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/simmem_pkg.sv
// Shared widths for the simulated-memory write-response path.
// Consumed as parameter defaults by the release scheduler.
package simmem_pkg;

  localparam int WriteRespBankAddrWidth = 4;
  localparam int DelayWidth             = 6;

endpackage

// File: rtl/simmem_release_scheduler.sv
// Holds identifiers for a programmed delay, then releases expired ones.
// Ports: clk_i/rst_ni, in (id, delay, valid/ready), out (id, valid/ready), occupancy.
module simmem_release_scheduler #(
  parameter int NumSlots   = 8,
  parameter int IdWidth    = simmem_pkg::WriteRespBankAddrWidth,
  parameter int DelayWidth = simmem_pkg::DelayWidth
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [IdWidth-1:0]          local_identifier_i,
  input  logic [DelayWidth-1:0]       delay_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic [IdWidth-1:0]          local_identifier_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [$clog2(NumSlots):0]   occupancy_o
);

  localparam int SlotW = $clog2(NumSlots);
  localparam int OccW  = SlotW + 1;

  logic [NumSlots-1:0]   r_occ;
  logic [IdWidth-1:0]    r_id  [NumSlots];
  logic [DelayWidth-1:0] r_cnt [NumSlots];
  logic [OccW-1:0]       r_occupancy;

  logic             w_has_free;
  logic             w_has_exp;
  logic [SlotW-1:0] w_free_idx;
  logic [SlotW-1:0] w_rel_idx;
  logic             w_accept;
  logic             w_release;

  // Descending scan: the last hit is the lowest index.
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    w_has_exp  = 1'b0;
    w_rel_idx  = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!r_occ[i]) begin
        w_has_free = 1'b1;
        w_free_idx = SlotW'(i);
      end
      if (r_occ[i] && (r_cnt[i] == '0)) begin
        w_has_exp = 1'b1;
        w_rel_idx = SlotW'(i);
      end
    end
  end

  assign in_ready_o         = w_has_free;
  assign out_valid_o        = w_has_exp;
  assign local_identifier_o = w_has_exp ? r_id[w_rel_idx] : '0;
  assign occupancy_o        = r_occupancy;

  assign w_accept  = in_valid_i & w_has_free;
  assign w_release = w_has_exp & out_ready_i;

  // The accepted slot was free at cycle start, so it never collides
  // with the released slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_occ       <= '0;
      r_occupancy <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        r_id[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (w_accept && (w_free_idx == SlotW'(i))) begin
          r_occ[i] <= 1'b1;
          r_id[i]  <= local_identifier_i;
          r_cnt[i] <= delay_i;
        end else begin
          if (w_release && (w_rel_idx == SlotW'(i))) begin
            r_occ[i] <= 1'b0;
          end
          if (r_occ[i] && (r_cnt[i] != '0)) begin
            r_cnt[i] <= r_cnt[i] - DelayWidth'(1);
          end
        end
      end
      unique case ({w_accept, w_release})
        2'b10:   r_occupancy <= r_occupancy + OccW'(1);
        2'b01:   r_occupancy <= r_occupancy - OccW'(1);
        default: r_occupancy <= r_occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Directed bench for the release scheduler with a release scoreboard.
// Drives after each rising edge, samples before the next one.
module tb_simmem_release_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] id_i;
  logic [5:0] dly;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] id_o;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] occ;

  int tests;
  int fails;
  int exp_q[$];

  simmem_release_scheduler dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .local_identifier_i (id_i),
    .delay_i            (dly),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .local_identifier_o (id_o),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .occupancy_o        (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Any release happening at the coming edge must match a pending id.
  task automatic tick();
    int idx;
    if (out_valid && out_ready) begin
      idx = -1;
      for (int k = 0; k < exp_q.size(); k++)
        if (idx < 0 && exp_q[k] == int'(id_o)) idx = k;
      chk("sb_release", (idx >= 0) ? 1 : 0, 1);
      if (idx >= 0) exp_q.delete(idx);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input int d);
    id_i     = 4'(id);
    dly      = 6'(d);
    in_valid = 1'b1;
    if (in_ready) exp_q.push_back(id);
  endtask

  task automatic wait_valid(input string tag, input int max);
    for (int n = 0; n < max && !out_valid; n++) tick();
    chk(tag, int'(out_valid), 1);
  endtask

  task automatic drain(input string tag, input int max);
    for (int n = 0; n < max && occ != 0; n++) tick();
    chk(tag, int'(occ), 0);
  endtask

  initial begin
    int bad;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    id_i      = '0;
    dly       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_id", int'(id_o), 0);
    chk("rst_occ", int'(occ), 0);
    rst_n = 1'b1;
    tick();

    // single: id 5, delay 10
    drive(5, 10);
    tick();
    in_valid = 1'b0;
    chk("single_occ1", int'(occ), 1);
    for (int k = 0; k < 10; k++) begin
      chk("single_early", int'(out_valid), 0);
      tick();
    end
    chk("single_valid", int'(out_valid), 1);
    chk("single_id", int'(id_o), 5);
    tick();
    chk("single_occ0", int'(occ), 0);
    chk("single_gone", int'(out_valid), 0);

    // zero delay
    drive(3, 0);
    tick();
    in_valid = 1'b0;
    chk("zero_valid", int'(out_valid), 1);
    chk("zero_id", int'(id_o), 3);
    tick();
    chk("zero_occ", int'(occ), 0);

    // full
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(i, 20);
      tick();
    end
    chk("full_ready", int'(in_ready), 0);
    chk("full_occ", int'(occ), 8);
    drive(9, 1);
    tick();
    in_valid = 1'b0;
    chk("full_ignored", int'(occ), 8);
    wait_valid("full_expire", 40);
    chk("full_first_id", int'(id_o), 0);
    out_ready = 1'b1;
    tick();
    chk("full_ready_back", int'(in_ready), 1);
    chk("full_occ7", int'(occ), 7);
    drain("full_drain", 30);
    chk("full_sb_empty", exp_q.size(), 0);

    // backpressure
    out_ready = 1'b0;
    drive(1, 2);
    tick();
    in_valid = 1'b0;
    chk("bp_early0", int'(out_valid), 0);
    tick();
    chk("bp_early1", int'(out_valid), 0);
    tick();
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_id", int'(id_o), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_id", int'(id_o), 1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_released", int'(out_valid), 0);
    chk("bp_occ", int'(occ), 0);

    // ordering and simultaneous accept/release
    drive(7, 4);
    tick();
    drive(2, 0);
    tick();
    in_valid = 1'b0;
    chk("ord_valid", int'(out_valid), 1);
    chk("ord_id2_first", int'(id_o), 2);
    chk("ord_occ2", int'(occ), 2);
    drive(4, 10);
    tick();
    in_valid = 1'b0;
    chk("simul_occ", int'(occ), 2);
    wait_valid("ord_id7_expire", 10);
    chk("ord_id7", int'(id_o), 7);
    tick();
    drain("ord_drain", 20);

    // reset mid-operation
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(i, 3);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("mid_pending", int'(occ), 3);
    chk("mid_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", int'(in_ready), 1);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_id", int'(id_o), 0);
    chk("mid_rst_occ", int'(occ), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid) bad++;
      tick();
    end
    chk("mid_no_release", bad, 0);
    chk("end_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
